// File: rtl/seg7_scan_driver_if.sv
// Display-driver bus: BCD value and control in from the timer logic,
// multiplexed segment/anode drive and frame strobe out to the pins.
interface seg7_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    load;
    logic                    blank_lz;
    logic                    blink_en;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_tick;

    modport master (
        output bcd_in, load, blank_lz, blink_en,
        input  seg, an, frame_tick
    );

    modport slave (
        input  bcd_in, load, blank_lz, blink_en,
        output seg, an, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver with shadowed digits, leading-zero blanking,
// whole-display blink and selectable segment/anode polarity.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned SCAN_DIV    = 1000,
    parameter int unsigned BLINK_DIV   = 500000,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          AN_ACT_LOW  = 1'b1
) (
    input logic               clk,
    input logic               reset,
    seg7_scan_driver_if.slave disp_io
);
    localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned ScanW  = $clog2(SCAN_DIV);
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0]            SegOff = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AnOff  = AN_ACT_LOW ? {NUM_DIGITS{1'b1}}
                                                          : {NUM_DIGITS{1'b0}};

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [ScanW-1:0]        scan_cnt_q, scan_cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [BlinkW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                    blink_ph_q, blink_ph_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                  scan_wrap, idx_last, blink_wrap, upper_zero, blank;
    logic [3:0]            cur_digit;
    logic [NUM_DIGITS-1:0] an_onehot;

    // Active-high {g,f,e,d,c,b,a}; anything beyond 9 renders as a dash.
    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b1000000;
        endcase
    endfunction

    always_comb begin
        shadow_d   = disp_io.load ? disp_io.bcd_in : shadow_q;
        scan_wrap  = (scan_cnt_q == ScanW'(SCAN_DIV - 1));
        idx_last   = (idx_q == IdxW'(NUM_DIGITS - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + ScanW'(1);
        idx_d      = idx_q;
        if (scan_wrap) begin
            idx_d = idx_last ? '0 : idx_q + IdxW'(1);
        end

        // Dropping blink_en parks the blink in its visible phase.
        blink_wrap  = (blink_cnt_q == BlinkW'(BLINK_DIV - 1));
        blink_cnt_d = '0;
        blink_ph_d  = 1'b0;
        if (disp_io.blink_en) begin
            blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BlinkW'(1);
            blink_ph_d  = blink_ph_q ^ blink_wrap;
        end

        cur_digit  = 4'h0;
        an_onehot  = '0;
        upper_zero = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_digit    = shadow_q[4*i +: 4];
                an_onehot[i] = 1'b1;
            end
            if (i >= int'(idx_q) && shadow_q[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        blank = disp_io.blank_lz && (idx_q != '0) && upper_zero;

        seg_d = blank ? SegOff : (decode(cur_digit) ^ {7{SEG_ACT_LOW}});
        if (scan_cnt_q == '0 || (disp_io.blink_en && blink_ph_q)) begin
            an_d = AnOff;
        end else begin
            an_d = an_onehot ^ AnOff;
        end
        frame_tick_d = scan_wrap && idx_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q     <= '0;
            scan_cnt_q   <= '0;
            idx_q        <= '0;
            blink_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
            seg_q        <= SegOff;
            an_q         <= AnOff;
            frame_tick_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            scan_cnt_q   <= scan_cnt_d;
            idx_q        <= idx_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_ph_q   <= blink_ph_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign disp_io.seg        = seg_q;
    assign disp_io.an         = an_q;
    assign disp_io.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4-cycle slots, 8-cycle blink half-period,
// active-low segments and anodes. Edges are numbered from the first edge after reset release.
module tb_seg7_scan_driver;
    logic clk;
    logic reset;
    int   cyc;
    int   n_assert;
    int   n_fail;

    seg7_scan_driver_if #(.NUM_DIGITS(4)) dbus ();

    seg7_scan_driver #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .BLINK_DIV  (8),
        .SEG_ACT_LOW(1'b1),
        .AN_ACT_LOW (1'b1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .disp_io(dbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string tag, input logic [6:0] s, input logic [3:0] a);
        n_assert++;
        assert (dbus.seg === s) else begin
            n_fail++;
            $error("FAIL %s seg: got %b expected %b (edge %0d)", tag, dbus.seg, s, cyc);
        end
        n_assert++;
        assert (dbus.an === a) else begin
            n_fail++;
            $error("FAIL %s an: got %b expected %b (edge %0d)", tag, dbus.an, a, cyc);
        end
    endtask

    task automatic chk_ft(input string tag, input logic f);
        n_assert++;
        assert (dbus.frame_tick === f) else begin
            n_fail++;
            $error("FAIL %s frame_tick: got %b expected %b (edge %0d)", tag, dbus.frame_tick,
                   f, cyc);
        end
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        cyc           = 0;
        reset         = 1'b1;
        dbus.bcd_in   = '0;
        dbus.load     = 1'b0;
        dbus.blank_lz = 1'b0;
        dbus.blink_en = 1'b0;
        repeat (3) tick();
        chk("reset", 7'h7F, 4'hF);
        chk_ft("reset", 1'b0);

        // Scan of 1234; load on E1 only reaches seg from E2.
        cyc         = 0;
        reset       = 1'b0;
        dbus.bcd_in = 16'h1234;
        dbus.load   = 1'b1;
        tick();
        dbus.load = 1'b0;
        chk("scan_e1", 7'b1000000, 4'hF);
        chk_ft("scan_e1", 1'b0);
        go(2);  chk("scan_d0", 7'b0011001, 4'hE);
        go(5);  chk("scan_ghost1", 7'b0110000, 4'hF);
        go(6);  chk("scan_d1", 7'b0110000, 4'hD);
        go(10); chk("scan_d2", 7'b0100100, 4'hB);
        go(14); chk("scan_d3", 7'b1111001, 4'h7);
        go(16); chk("scan_d3_end", 7'b1111001, 4'h7);
        chk_ft("ft_e16", 1'b1);
        go(17); chk("scan_wrap", 7'b0011001, 4'hF);
        chk_ft("ft_e17", 1'b0);
        go(31); chk_ft("ft_e31", 1'b0);
        go(32); chk_ft("ft_e32", 1'b1);

        // Leading-zero blanking of 0050, then 0000.
        dbus.blank_lz = 1'b1;
        dbus.bcd_in   = 16'h0050;
        dbus.load     = 1'b1;
        tick();
        dbus.load = 1'b0;
        chk("lz_e33", 7'b0011001, 4'hF);
        go(34); chk("lz_d0", 7'b1000000, 4'hE);
        go(38); chk("lz_d1", 7'b0010010, 4'hD);
        go(42); chk("lz_d2", 7'h7F, 4'hB);
        go(46); chk("lz_d3", 7'h7F, 4'h7);
        go(48);
        dbus.bcd_in = 16'h0000;
        dbus.load   = 1'b1;
        tick();
        dbus.load = 1'b0;
        go(50); chk("lz0_d0", 7'b1000000, 4'hE);
        go(54); chk("lz0_d1", 7'h7F, 4'hD);
        go(58); chk("lz0_d2", 7'h7F, 4'hB);

        // Invalid code 0xA renders as a dash and is never blanked.
        go(64);
        dbus.blank_lz = 1'b0;
        dbus.bcd_in   = 16'h00A0;
        dbus.load     = 1'b1;
        tick();
        dbus.load = 1'b0;
        go(66); chk("inv_d0", 7'b1000000, 4'hE);
        go(70); chk("inv_d1", 7'b0111111, 4'hD);
        dbus.blank_lz = 1'b1;
        tick(); chk("inv_d1_lz", 7'b0111111, 4'hD);
        go(74); chk("inv_d2_lz", 7'h7F, 4'hB);
        dbus.blank_lz = 1'b0;
        go(78); chk("inv_d3_nolz", 7'b1000000, 4'h7);

        // Blink enabled from E81: dark for E89..E96 and E105..E112 unless dropped.
        go(80);
        dbus.blink_en = 1'b1;
        go(88);  chk("blink_vis", 7'b0111111, 4'hD);
        go(89);  chk("blink_dark0", 7'b1000000, 4'hF);
        go(90);  chk("blink_dark1", 7'b1000000, 4'hF);
        go(96);  chk("blink_dark7", 7'b1000000, 4'hF);
        go(98);  chk("blink_back", 7'b1000000, 4'hE);
        go(106); chk("blink_dark2", 7'b1000000, 4'hF);
        dbus.blink_en = 1'b0;
        go(107); chk("blink_drop", 7'b1000000, 4'hB);
        go(108); chk("blink_drop2", 7'b1000000, 4'hB);

        // Load on the idx-advance edge E112: new digit0 appears from E113.
        go(111);
        dbus.bcd_in = 16'h9876;
        dbus.load   = 1'b1;
        tick();
        dbus.load = 1'b0;
        chk("coll_e112", 7'b1000000, 4'h7);
        go(113); chk("coll_e113", 7'b0000010, 4'hF);
        go(114); chk("coll_e114", 7'b0000010, 4'hE);

        // Reset while digit2 is being scanned.
        go(121);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid", 7'h7F, 4'hF);
        chk_ft("rst_mid", 1'b0);
        tick(); chk("rst_dark", 7'b1000000, 4'hF);
        tick(); chk("rst_d0", 7'b1000000, 4'hE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
